// File: rtl/programmable_frequency_divider.sv
// ---------------------------------------------------------------------------
// programmable_frequency_divider
//
// Divides the system clock by 2*(DIV+1). The counter runs over 0..DIV; the
// cycle in which it has reached DIV is the "wrap cycle". On the edge that ends
// a wrap cycle, CLK_OUT inverts, TICK pulses for one cycle and the counter
// restarts at 0.
//
// A new divisor requested while running is parked in a shadow register and
// only takes effect at a period boundary. Because of this, no half-period is
// ever built from two different divisors.
//
// LOAD protocol: LOAD is a single-cycle strobe. DIVISOR is sampled on the
// rising edge where LOAD=1. There is no back-pressure, and a later strobe
// simply supersedes an earlier one.
//
// Ports
//   IN_50Mhz   in   system clock; all state changes on its rising edge
//   RESET      in   synchronous, active-high; overrides LOAD and ENABLE
//   ENABLE     in   1 = divider runs, 0 = divider frozen
//   LOAD       in   request to change the divisor
//   DIVISOR    in   [COUNTER_WIDTH] new divisor, sampled when LOAD=1
//   CLK_OUT    out  divided square wave (registered)
//   TICK       out  one-cycle pulse following every CLK_OUT toggle (registered)
//   PENDING    out  a loaded divisor is waiting for the next boundary
//   ACTIVE_DIV out  [COUNTER_WIDTH] divisor currently in use
// ---------------------------------------------------------------------------
module programmable_frequency_divider #(
  parameter int COUNTER_WIDTH   = 6,
  parameter int DEFAULT_DIVISOR = 63
) (
  input  logic                     IN_50Mhz,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic                     LOAD,
  input  logic [COUNTER_WIDTH-1:0] DIVISOR,
  output logic                     CLK_OUT,
  output logic                     TICK,
  output logic                     PENDING,
  output logic [COUNTER_WIDTH-1:0] ACTIVE_DIV
);

  localparam logic [COUNTER_WIDTH-1:0] DEF_DIV = COUNTER_WIDTH'(DEFAULT_DIVISOR);

  // The declaration initialisers give a power-up state identical to reset.
  logic [COUNTER_WIDTH-1:0] counter_q = '0;
  logic [COUNTER_WIDTH-1:0] div_q     = DEF_DIV;
  logic [COUNTER_WIDTH-1:0] shadow_q  = '0;
  logic                     pend_q    = 1'b0;
  logic                     clk_q     = 1'b0;
  logic                     tick_q    = 1'b0;

  logic [COUNTER_WIDTH-1:0] counter_d;
  logic [COUNTER_WIDTH-1:0] div_d;
  logic [COUNTER_WIDTH-1:0] shadow_d;
  logic                     pend_d;
  logic                     clk_d;
  logic                     tick_d;
  logic                     wrap;

  // The wrap test uses >= so that the counter can never run past the divisor,
  // even if the counter is ever found above the active divisor.
  assign wrap = ENABLE && (counter_q >= div_q);

  always_comb begin
    counter_d = counter_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;

    if (!ENABLE) begin
      // Frozen. A load takes effect immediately because there is no running
      // period to protect. CLK_OUT keeps its level.
      if (LOAD) begin
        div_d     = DIVISOR;
        counter_d = '0;
        pend_d    = 1'b0;
      end
    end else if (wrap) begin
      counter_d = '0;
      clk_d     = ~clk_q;
      tick_d    = 1'b1;
      // A load arriving on the boundary itself wins over any older shadow.
      if (LOAD) begin
        div_d  = DIVISOR;
        pend_d = 1'b0;
      end else if (pend_q) begin
        div_d  = shadow_q;
        pend_d = 1'b0;
      end
    end else begin
      counter_d = counter_q + 1'b1;
      if (LOAD) begin
        shadow_d = DIVISOR;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge IN_50Mhz) begin
    if (RESET) begin
      counter_q <= '0;
      div_q     <= DEF_DIV;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign CLK_OUT    = clk_q;
  assign TICK       = tick_q;
  assign PENDING    = pend_q;
  assign ACTIVE_DIV = div_q;

endmodule

// File: tb/tb_programmable_frequency_divider.sv
module tb_programmable_frequency_divider;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ld;
  logic [W-1:0] divisor;
  logic         clk_out;
  logic         tick;
  logic         pending;
  logic [W-1:0] active_div;

  int checks = 0;
  int errors = 0;

  // Clock and reset
  always #5 clk = ~clk;

  programmable_frequency_divider #(
    .COUNTER_WIDTH  (W),
    .DEFAULT_DIVISOR(63)
  ) dut (
    .IN_50Mhz  (clk),
    .RESET     (rst),
    .ENABLE    (en),
    .LOAD      (ld),
    .DIVISOR   (divisor),
    .CLK_OUT   (clk_out),
    .TICK      (tick),
    .PENDING   (pending),
    .ACTIVE_DIV(active_div)
  );

  // Driver tasks. Inputs change and outputs are sampled 1 time unit after
  // each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps until TICK is seen high. Returns the number of edges taken, or the
  // budget if TICK never appears.
  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (tick !== 1'b1 && cycles < budget);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; ld = 1'b1; divisor = 6'd5;
    step(1);
    rst = 1'b0; ld = 1'b0;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (active_div !== 6'd63) begin errors++; $display("FAIL reset_active_div got=%0d exp=63", active_div); end
  endtask

  task automatic test_default_run;
    int n;
    logic exp_clk;
    exp_clk = 1'b0;
    for (int h = 0; h < 4; h++) begin
      wait_tick(200, n);
      exp_clk = ~exp_clk;
      checks++; if (n !== 64) begin errors++; $display("FAIL default_half_period[%0d] got=%0d exp=64", h, n); end
      checks++; if (clk_out !== exp_clk) begin errors++; $display("FAIL default_clk_out[%0d] got=%b exp=%b", h, clk_out, exp_clk); end
    end
    checks++; if (active_div !== 6'd63) begin errors++; $display("FAIL default_active_div got=%0d exp=63", active_div); end
    step(1);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL default_tick_width got=%b exp=0", tick); end
    // Finish this half-period so the next test starts right after a tick.
    wait_tick(200, n);
    checks++; if (n !== 63) begin errors++; $display("FAIL default_tail got=%0d exp=63", n); end
  endtask

  task automatic test_reload;
    int n;
    // Counter is 0 right after the tick; 10 steps bring it to 10.
    step(10);
    ld = 1'b1; divisor = 6'd3;
    step(1);
    ld = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL reload_pending got=%b exp=1", pending); end
    checks++; if (active_div !== 6'd63) begin errors++; $display("FAIL reload_div_held got=%0d exp=63", active_div); end
    wait_tick(200, n);
    checks++; if (11 + n !== 64) begin errors++; $display("FAIL reload_current_half got=%0d exp=64", 11 + n); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reload_pending_clear got=%b exp=0", pending); end
    checks++; if (active_div !== 6'd3) begin errors++; $display("FAIL reload_new_div got=%0d exp=3", active_div); end
    for (int h = 0; h < 2; h++) begin
      wait_tick(200, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL reload_new_half[%0d] got=%0d exp=4", h, n); end
    end
  endtask

  task automatic test_load_on_wrap;
    int n;
    // DIV=3, counter 0: three steps reach 3, so the next cycle is a wrap.
    step(3);
    ld = 1'b1; divisor = 6'd5;
    step(1);
    ld = 1'b0;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL wrap_load_tick got=%b exp=1", tick); end
    checks++; if (active_div !== 6'd5) begin errors++; $display("FAIL wrap_load_div got=%0d exp=5", active_div); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL wrap_load_pending got=%b exp=0", pending); end
    wait_tick(200, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL wrap_load_half got=%0d exp=6", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    ld = 1'b1; divisor = 6'd7;
    step(1);
    divisor = 6'd2;
    step(1);
    ld = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL double_pending got=%b exp=1", pending); end
    checks++; if (active_div !== 6'd5) begin errors++; $display("FAIL double_div_held got=%0d exp=5", active_div); end
    wait_tick(200, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL double_current_half got=%0d exp=4", n); end
    checks++; if (active_div !== 6'd2) begin errors++; $display("FAIL double_last_wins got=%0d exp=2", active_div); end
    wait_tick(200, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL double_new_half got=%0d exp=3", n); end
  endtask

  task automatic test_div_zero;
    logic prev;
    en = 1'b0; ld = 1'b1; divisor = 6'd0;
    step(1);
    ld = 1'b0;
    checks++; if (active_div !== 6'd0) begin errors++; $display("FAIL zero_div got=%0d exp=0", active_div); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL zero_tick_frozen got=%b exp=0", tick); end
    en = 1'b1;
    prev = clk_out;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL zero_tick[%0d] got=%b exp=1", i, tick); end
      checks++; if (clk_out !== ~prev) begin errors++; $display("FAIL zero_toggle[%0d] got=%b exp=%b", i, clk_out, ~prev); end
      prev = ~prev;
    end
  endtask

  task automatic test_freeze;
    int n;
    int bad;
    logic held;
    en = 1'b0; ld = 1'b1; divisor = 6'd63;
    step(1);
    ld = 1'b0; en = 1'b1;
    step(20);
    held = clk_out;
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (clk_out !== held || tick !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL freeze_hold got=%0d bad cycles exp=0", bad); end
    en = 1'b1;
    wait_tick(200, n);
    checks++; if (n !== 44) begin errors++; $display("FAIL freeze_resume got=%0d exp=44", n); end
    checks++; if (clk_out !== ~held) begin errors++; $display("FAIL freeze_toggle got=%b exp=%b", clk_out, ~held); end
  endtask

  task automatic test_reset_mid;
    int n;
    step(30);
    ld = 1'b1; divisor = 6'd3;
    step(1);
    ld = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL midrst_pending_before got=%b exp=1", pending); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL midrst_clk_out got=%b exp=0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got=%b exp=0", tick); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL midrst_pending got=%b exp=0", pending); end
    checks++; if (active_div !== 6'd63) begin errors++; $display("FAIL midrst_div got=%0d exp=63", active_div); end
    wait_tick(200, n);
    checks++; if (n !== 64) begin errors++; $display("FAIL midrst_first_toggle got=%0d exp=64", n); end
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL midrst_clk_after got=%b exp=1", clk_out); end
    checks++; if (active_div !== 6'd63) begin errors++; $display("FAIL midrst_div_after got=%0d exp=63", active_div); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; divisor = '0;
    step(2);
    test_reset;
    test_default_run;
    test_reload;
    test_load_on_wrap;
    test_back_to_back;
    test_div_zero;
    test_freeze;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
